// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-organised data memory for one request at a time.
// Sub-word stores are performed as read-modify-write of the containing word.
module load_store_unit #(
  parameter int unsigned WORD_COUNT = 128,
  parameter int unsigned WORD_BITS  = 32,
  localparam int unsigned ADDR_BITS = $clog2(WORD_COUNT * WORD_BITS / 8)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_write,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_unsigned,
  input  logic [31:0]          i_req_addr,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_resp_valid,
  output logic [31:0]          o_resp_rdata,
  output logic                 o_resp_err,
  output logic [ADDR_BITS-1:0] o_mem_address,
  input  logic [31:0]          i_mem_rd_data,
  output logic [31:0]          o_mem_wr_data,
  output logic                 o_mem_wr_en
);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [1:0]            r_size;
  logic                  r_write;
  logic                  r_unsigned;
  logic [15:0]           r_wdata;
  logic [31:0]           r_merge;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_misaligned;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_data;
  logic [31:0]           w_merge_data;
  logic                  w_unused_addr_hi;

  // Upper address bits alias onto the same memory words.
  assign w_unused_addr_hi = ^i_req_addr[31:ADDR_BITS];
  assign w_accept         = i_req_valid && (r_state == StIdle);

  always_comb begin
    w_misaligned = 1'b0;
    unique case (i_req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = i_req_addr[0];
      2'b10:   w_misaligned = |i_req_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    w_byte      = i_mem_rd_data[{r_addr[1:0], 3'b000} +: 8];
    w_half      = r_addr[1] ? i_mem_rd_data[31:16] : i_mem_rd_data[15:0];
    w_load_data = i_mem_rd_data;
    unique case (r_size)
      2'b00:   w_load_data = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = i_mem_rd_data;
    endcase
  end

  always_comb begin
    w_merge_data = i_mem_rd_data;
    if (r_size == 2'b00) begin
      w_merge_data[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_addr[1]) begin
      w_merge_data[31:16] = r_wdata;
    end else begin
      w_merge_data[15:0] = r_wdata;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_misaligned)              w_state_next = StResp;
          else if (!i_req_write)         w_state_next = StLoad;
          else if (i_req_size == 2'b10)  w_state_next = StWrite;
          else                           w_state_next = StMerge;
        end
      end
      StLoad:  w_state_next = StResp;
      StMerge: w_state_next = StWrite;
      StWrite: w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= 16'b0;
      r_merge    <= 32'b0;
      r_rdata    <= 32'b0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_addr     <= i_req_addr[ADDR_BITS-1:0];
            r_size     <= i_req_size;
            r_write    <= i_req_write;
            r_unsigned <= i_req_unsigned;
            r_wdata    <= i_req_wdata[15:0];
            r_err      <= w_misaligned;
            if (i_req_write && (i_req_size == 2'b10) && !w_misaligned) begin
              r_merge <= i_req_wdata;
            end
          end
        end
        StLoad:  r_rdata <= w_load_data;
        StMerge: r_merge <= w_merge_data;
        StWrite: ;
        StResp: begin
          r_rdata <= 32'b0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Write strobe is a pure state decode so an async reset removes it at once.
  assign o_req_ready   = (r_state == StIdle);
  assign o_resp_valid  = (r_state == StResp);
  assign o_resp_rdata  = (o_resp_valid && !r_write) ? r_rdata : 32'b0;
  assign o_resp_err    = o_resp_valid && r_err;
  assign o_mem_address = {r_addr[ADDR_BITS-1:2], 2'b00};
  assign o_mem_wr_en   = (r_state == StWrite);
  assign o_mem_wr_data = o_mem_wr_en ? r_merge : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests against a behavioural memory,
// with a response scoreboard popped by an independent monitor.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [8:0]  mem_address;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;

  logic [31:0] mem [0:127];
  logic        pre_en;
  logic [6:0]  pre_idx;
  logic [31:0] pre_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          checks;
  int          failures;
  int          wr_count;
  int          wr_cyc;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  load_store_unit dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_mem_address  (mem_address),
    .i_mem_rd_data  (mem_rd_data),
    .o_mem_wr_data  (mem_wr_data),
    .o_mem_wr_en    (mem_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rd_data = mem[mem_address[8:2]];
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_wr_en) mem[mem_address[8:2]] <= mem_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response and records write strobes.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0d expected no response",
                 resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_cycle", cyc, e.due);
      end
    end
    if (mem_wr_en) begin
      wr_count++;
      wr_cyc  = cyc;
      wr_addr = {23'b0, mem_address};
      wr_data = mem_wr_data;
    end
  end

  // Presents a request; acc is the cycle count at the negedge before the accept edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic want,
                       input logic [31:0] er, input logic ee, input int lat, output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      acc = cyc;
      if (want) begin
        e.rdata = er;
        e.err   = ee;
        e.due   = cyc + lat;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  int acc1;
  int acc2;
  int wr_before;
  int n;

  initial begin
    cyc = 0; checks = 0; failures = 0; wr_count = 0; wr_cyc = 0;
    wr_addr = 0; wr_data = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
    pre_en = 1'b1; pre_idx = 7'd4; pre_data = 32'h8899AABB;
    @(posedge clk);
    @(posedge clk);
    #1 pre_en = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_address", {23'b0, mem_address}, 32'd0);
    chk("rst_mem_wr_data", mem_wr_data, 32'd0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    rst = 1'b0;

    // Loads from the preloaded word 0x8899AABB.
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0, 2, acc1);
    req_valid = 1'b0;
    drain();
    issue(1'b0, 2'b00, 1'b1, 32'h213, 32'h0, 1'b1, 32'h00000088, 1'b0, 2, acc1);
    req_valid = 1'b0;
    drain();
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 32'hFFFF8899, 1'b0, 2, acc1);
    req_valid = 1'b0;
    drain();
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000AABB, 1'b0, 2, acc1);
    req_valid = 1'b0;
    drain();

    // Byte store read-modify-write.
    wr_before = wr_count;
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF5C, 1'b1, 32'h0, 1'b0, 3, acc1);
    req_valid = 1'b0;
    drain();
    chk("sb_wr_pulses", wr_count - wr_before, 32'd1);
    chk("sb_wr_addr", wr_addr, 32'h10);
    chk("sb_wr_data", wr_data, 32'h885CAABB);
    chk("sb_wr_cycle", wr_cyc, acc1 + 2);
    chk("sb_mem_word", mem[4], 32'h885CAABB);

    // Misaligned halfword store and illegal-size load: error, no memory write.
    wr_before = wr_count;
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 1'b1, 32'h0, 1'b1, 1, acc1);
    req_valid = 1'b0;
    drain();
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1, acc1);
    req_valid = 1'b0;
    drain();
    chk("err_no_write", wr_count - wr_before, 32'd0);
    chk("err_mem_word", mem[4], 32'h885CAABB);

    // Word store then load with valid held high throughout.
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2, acc1);
    chk("busy_ready_low", {31'b0, req_ready}, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2, acc2);
    req_valid = 1'b0;
    chk("b2b_accept_gap", acc2 - acc1, 32'd3);
    drain();

    // Reset during the WRITE state of a byte store.
    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h77, 1'b0, 32'h0, 1'b0, 0, acc1);
    req_valid = 1'b0;
    n = 0;
    while (!mem_wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_write", {31'b0, mem_wr_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_en_drop", {31'b0, mem_wr_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_mem_word", mem[4], 32'h885CAABB);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("rst_mid_no_resp", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute stage and drives the word-organised data memory's address / write-data / write-enable port.
- Sub-word stores are done as read-modify-write, because the memory only supports full-word writes. Memory reads are combinational; memory writes take effect on the clock edge.
- Sits between the pipeline's memory stage and the data memory.

Parameters:
WORD_COUNT, 128, number of words in the attached data memory
WORD_BITS, 32, word width; fixed at 32 (byte lanes hard-wired)
ADDR_BITS, clog2(WORD_COUNT*WORD_BITS/8) = 9, derived (not overridable); memory byte-address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address; bits above ADDR_BITS-1 ignored (aliasing)
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned/illegal request, qualified by resp_valid
mem_address  out  ADDR_BITS  word-aligned byte address to memory (low 2 bits always 0)
mem_rd_data  in  32  combinational read data from memory
mem_wr_data  out  32  full word to write
mem_wr_en  out  1  write strobe, one cycle

Behaviour:
- Reset: state IDLE. All holding registers (addr, size, write, unsigned, wdata, merge, rdata) are cleared. Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_address=0, mem_wr_data=0, mem_wr_en=0.
- Handshake: accept on a rising edge with req_valid && req_ready. All req_* fields are captured into holding registers; the inputs are don't-care afterwards.
- mem_address = {held_addr[ADDR_BITS-1:2], 2'b00} in every state.
- mem_wr_en is decoded from state (WRITE only), never registered.
- Lane select: lane = held_addr[1:0].
- Misaligned (checked at accept): halfword with addr[0]=1, word with addr[1:0]!=0, or size=11.
- States and transitions:
  - IDLE: req_ready=1. On accept: misaligned -> RESP with err flag set; load -> LOAD; word store -> WRITE (merge reg = req_wdata); sub-word store -> MERGE.
  - LOAD: capture the extended load result into rdata reg -> RESP.
    - Byte: mem_rd_data[8*lane+:8].
    - Halfword: mem_rd_data[16*addr[1]+:16].
    - Word: mem_rd_data as-is.
    - Sign- or zero-extend per req_unsigned.
  - MERGE: merge reg = mem_rd_data with the target byte/halfword lane replaced by wdata[7:0] / wdata[15:0] -> WRITE.
  - WRITE: mem_wr_en=1, mem_wr_data=merge reg; memory updates at the end of this cycle -> RESP.
  - RESP: resp_valid=1, resp_rdata=rdata reg (0 unless load), resp_err=err flag; unconditional -> IDLE. There is no response backpressure. rdata and err are cleared on exit.
- Latency from the accept edge to resp_valid high:
  - misaligned: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput: at most one request in flight. req_ready stays low from accept until IDLE is re-entered, so back-to-back requests are separated by the full latency plus one cycle.
- Errors perform no memory access: mem_wr_en is never asserted for an erroring request.
- Reset asserted mid-operation: immediate return to IDLE. mem_wr_en drops asynchronously, no partial write occurs, and the pending response is discarded.
- Address aliasing: req_addr bits above ADDR_BITS-1 are dropped. 0x210 accesses the same word as 0x010.

Test Plan:
- Preload word 0x10 = 0x8899AABB; load byte signed @0x11 -> resp_valid 2 cycles after accept, resp_rdata=0xFFFFFFAA, resp_err=0.
- Same preload; load byte unsigned @0x213 (alias) -> resp_rdata=0x00000088; load half signed @0x12 -> 0xFFFF8899.
- Store byte 0x5C @0x12 -> exactly one mem_wr_en pulse, 2 cycles after accept, mem_address=0x10, mem_wr_data=0x885CAABB; resp_valid 3 cycles after accept, resp_rdata=0.
- Store half 0x1234 @0x11 (misaligned) -> resp_valid+resp_err 1 cycle after accept, no mem_wr_en, word 0x10 unchanged.
- Store word 0xDEADBEEF @0x20 with req_valid held high, then load word @0x20 -> req_ready low while busy; second request accepted only in IDLE; load returns 0xDEADBEEF.
- Assert reset during the WRITE state of a byte store -> mem_wr_en falls immediately, memory word unchanged, no resp_valid, req_ready=1 after reset.
